// File: rtl/mul_div_unit_if.sv
// Request/response bundle between a requester and the iterative multiply/divide unit.
// The requester drives the strobe, opcode and operands; the unit answers with busy/done/result.
interface mul_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [4:0]       aluOpcode;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (
        output start,
        output aluOpcode,
        output operandA,
        output operandB,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  aluOpcode,
        input  operandA,
        input  operandB,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide,
// one bit per clock over WIDTH cycles, with divide-by-zero and signed-overflow
// divides short-circuited straight to the finish state.
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mul_div_unit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MUL_ITER,
        DIV_ITER,
        FINISH
    } stateType;

    stateType state;
    stateType nextState;

    logic [CW-1:0]      counter;
    logic [2:0]         opReg;
    logic               negResult;
    logic               remNeg;
    logic               special;
    logic [2*WIDTH-1:0] multiplicand;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   multiplier;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   divisor;
    logic [WIDTH-1:0]   resultReg;

    logic [2:0]       inOp;
    logic             inASigned;
    logic             inBSigned;
    logic             inANeg;
    logic             inBNeg;
    logic [WIDTH-1:0] inAMag;
    logic [WIDTH-1:0] inBMag;
    logic             divZero;
    logic             divOverflow;
    logic             accept;

    logic [WIDTH:0]   partial;
    logic             divFits;
    logic [WIDTH-1:0] divDiff;

    logic [2*WIDTH-1:0] productFinal;
    logic [WIDTH-1:0]   quotientFinal;
    logic [WIDTH-1:0]   remainderFinal;
    logic [WIDTH-1:0]   finalValue;

    // Decode the incoming request: which operands are signed, their magnitudes,
    // and whether this divide is one of the two cases that skip iteration.
    assign inOp        = bus.aluOpcode[2:0];
    assign inASigned   = (inOp == 3'b000) || (inOp == 3'b001) || (inOp == 3'b010) ||
                         (inOp == 3'b100) || (inOp == 3'b110);
    assign inBSigned   = (inOp == 3'b000) || (inOp == 3'b001) ||
                         (inOp == 3'b100) || (inOp == 3'b110);
    assign inANeg      = inASigned & bus.operandA[WIDTH-1];
    assign inBNeg      = inBSigned & bus.operandB[WIDTH-1];
    assign inAMag      = inANeg ? (~bus.operandA + 1'b1) : bus.operandA;
    assign inBMag      = inBNeg ? (~bus.operandB + 1'b1) : bus.operandB;
    assign divZero     = (bus.operandB == '0);
    assign divOverflow = ((inOp == 3'b100) || (inOp == 3'b110)) &&
                         (bus.operandA == MOST_NEG) && (bus.operandB == '1);
    assign accept      = bus.start && (state == IDLE) && (bus.aluOpcode[4:3] == 2'b01);

    // Restoring-divide step: shift the next dividend bit into the partial
    // remainder and subtract the divisor whenever it fits.
    assign partial = {remainder, quotient[WIDTH-1]};
    assign divFits = (partial >= {1'b0, divisor});
    assign divDiff = partial[WIDTH-1:0] - divisor;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state selection: multiplies and ordinary divides iterate, special
    // divides already hold their answer and go straight to FINISH.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!inOp[2]) begin
                        nextState = MUL_ITER;
                    end else if (divZero || divOverflow) begin
                        nextState = FINISH;
                    end else begin
                        nextState = DIV_ITER;
                    end
                end
            end
            MUL_ITER: begin
                if (counter == '0) begin
                    nextState = FINISH;
                end
            end
            DIV_ITER: begin
                if (counter == '0) begin
                    nextState = FINISH;
                end
            end
            FINISH: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Iteration counter: loaded with WIDTH-1 at accept, counts down once per iteration.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
        end else if (accept) begin
            counter <= CW'(WIDTH - 1);
        end else if (((state == MUL_ITER) || (state == DIV_ITER)) && (counter != '0)) begin
            counter <= counter - CW'(1);
        end
    end

    // Operand capture at accept and the per-cycle multiply/divide accumulators.
    always_ff @(posedge clk) begin
        if (reset) begin
            opReg        <= '0;
            negResult    <= 1'b0;
            remNeg       <= 1'b0;
            special      <= 1'b0;
            multiplicand <= '0;
            multiplier   <= '0;
            product      <= '0;
            quotient     <= '0;
            remainder    <= '0;
            divisor      <= '0;
        end else if (accept) begin
            opReg        <= inOp;
            negResult    <= inANeg ^ inBNeg;
            remNeg       <= inANeg;
            special      <= inOp[2] & (divZero | divOverflow);
            multiplicand <= {{WIDTH{1'b0}}, inAMag};
            multiplier   <= inBMag;
            product      <= '0;
            divisor      <= inBMag;
            if (divZero) begin
                quotient  <= '1;
                remainder <= bus.operandA;
            end else if (divOverflow) begin
                quotient  <= bus.operandA;
                remainder <= '0;
            end else begin
                quotient  <= inAMag;
                remainder <= '0;
            end
        end else if (state == MUL_ITER) begin
            if (multiplier[0]) begin
                product <= product + multiplicand;
            end
            multiplicand <= multiplicand << 1;
            multiplier   <= multiplier >> 1;
        end else if (state == DIV_ITER) begin
            remainder <= divFits ? divDiff : partial[WIDTH-1:0];
            quotient  <= {quotient[WIDTH-2:0], divFits};
        end
    end

    // Sign correction and result selection; only meaningful in FINISH.
    always_comb begin
        productFinal   = negResult ? (~product + 1'b1) : product;
        quotientFinal  = (negResult && !special) ? (~quotient + 1'b1) : quotient;
        remainderFinal = (remNeg && !special) ? (~remainder + 1'b1) : remainder;
        finalValue     = '0;
        case (opReg)
            3'b000:                 finalValue = productFinal[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: finalValue = productFinal[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         finalValue = quotientFinal;
            default:                finalValue = remainderFinal;
        endcase
    end

    // Result holding register: captures the finished value so it stays put
    // until the next operation finishes or reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            resultReg <= '0;
        end else if (state == FINISH) begin
            resultReg <= finalValue;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == FINISH);
    assign bus.result = (state == FINISH) ? finalValue : resultReg;

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and result width; iteration count equals WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request strobe; sampled only when busy=0.
REQ-005 aluOpcode  input  5  ALU opcode {funct7[6], funct7[0], funct3}; unit serves 5'b01xxx only.
REQ-006 operandA  input  WIDTH  rs1 value (multiplicand / dividend).
REQ-007 operandB  input  WIDTH  rs2 value (multiplier / divisor).
REQ-008 busy  output  1  high while an accepted operation is in flight (including the done cycle).
REQ-009 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-010 result  output  WIDTH  operation result; holds until the next accepted start or reset.

Function
REQ-011 Opcode map (low 3 bits): 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-012 Accept = start & ~busy & (aluOpcode[4:3]==2'b01); start with any other aluOpcode[4:3] is ignored (no state change, no done).
REQ-013 start while busy=1 is ignored; operands and opcode are latched only at accept.
REQ-014 States: IDLE, MUL_ITER, DIV_ITER, FINISH; IDLE->MUL_ITER on accepted 000-011, IDLE->DIV_ITER on accepted 100-111 with non-special operands, IDLE->FINISH on accepted special-case divide.
REQ-015 MUL_ITER/DIV_ITER run exactly WIDTH cycles (counter WIDTH-1 down to 0), then go to FINISH; FINISH asserts done and returns to IDLE next cycle.
REQ-016 Normal latency: accept at edge N, done=1 in cycle N+WIDTH+1 (cycle 33 for WIDTH=32); busy=1 cycles N+1..N+WIDTH+1.
REQ-017 Signedness: MUL/MULH/DIV/REM both signed; MULHSU operandA signed, operandB unsigned; MULHU/DIVU/REMU unsigned.
REQ-018 Multiply: shift-add on magnitudes into a 2*WIDTH product; negate product at FINISH if operand signs differ (signed operands only).
REQ-019 MUL returns product[WIDTH-1:0]; MULH/MULHSU/MULHU return product[2*WIDTH-1:WIDTH].
REQ-020 Divide: restoring division on magnitudes, one quotient bit per cycle, MSB first.
REQ-021 Signed quotient negated if dividend and divisor signs differ; signed remainder takes the dividend's sign.
REQ-022 Divide by zero (operandB==0): quotient all-ones, remainder = operandA; FINISH entered directly, done in cycle N+1.
REQ-023 Signed overflow (DIV/REM, operandA=most-negative, operandB=all-ones): quotient = operandA, remainder = 0; done in cycle N+1.
REQ-024 A new start sampled in the done cycle is ignored (busy=1); it is accepted earliest in the cycle after done.
REQ-025 result is updated only in the FINISH cycle; intermediate accumulators never appear on result.

Reset
REQ-026 reset=1 forces state IDLE, counter 0, busy=0, done=0, result=0 at the next edge, overriding start.
REQ-027 reset asserted mid-operation aborts it; no done pulse is produced for the aborted operation and result reads 0.
REQ-028 First accept possible in the cycle after reset deasserts.

Verification
REQ-029 MUL, A=7, B=0xFFFFFFFD (-3), accept cycle 0 -> done=1 in cycle 33 only, result=0xFFFFFFEB; MULHU same operands -> result=0x00000006.
REQ-030 MULH A=B=0x80000000 -> result=0x40000000; MULHSU A=0xFFFFFFFF, B=0xFFFFFFFF -> result=0xFFFFFFFF.
REQ-031 DIVU A=100, B=7 -> 14; REMU -> 2; DIV A=-7, B=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; each done at cycle 33.
REQ-032 DIV A=5, B=0 -> 0xFFFFFFFF, REMU A=5, B=0 -> 5, DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, REM same -> 0; all done in cycle 1.
REQ-033 Second start held high during cycles 1-33 with different operands -> ignored; result reflects first operation only; second accepted at cycle 34.
REQ-034 reset pulsed in cycle 10 of a DIVU -> busy=0 and result=0 from cycle 11, no done pulse; start with aluOpcode=5'b00000 -> busy stays 0.
